mem_load_responder: RTL and testbench

- Memory-side responder for the CPU LOAD handshake.
- Accepts a load request carrying the MAR address and issues a read to synchronous data memory with fixed latency.
- Returns the read word on load_to_mdr with a one-cycle is_loaded pulse. The CPU holds pc and the request until that pulse.
- Sits between the CPU hub and the data RAM; one outstanding load at a time.

---
 rtl/mem_load_responder_pkg.sv | 21 ++
 rtl/mem_load_responder_if.sv | 36 +++
 rtl/mem_load_responder.sv | 116 +++++++++++
 tb/tb_mem_load_responder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_load_responder_pkg.sv
// Shared definitions for the CPU load path: opcode constants, the load
// responder state encoding and default bus widths.
package mem_load_responder_pkg;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_ADDR_W  = 16;
  localparam int CNT_W       = 4;
  localparam int MAX_LATENCY = 15;

  localparam logic [7:0] OP_MOVE = 8'h01;
  localparam logic [7:0] OP_LOAD = 8'h02;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } load_state_t;

endpackage

// File: rtl/mem_load_responder_if.sv
// Bundle of the CPU load handshake and the data-RAM read port.
//
// Handshake: the CPU raises load_req (level) with load_addr and keeps it high
// until it sees is_loaded. load_addr is sampled only on the cycle the
// responder accepts the request (IDLE with load_req high). is_loaded is a
// single-cycle pulse and load_to_mdr is valid in that same cycle. Dropping
// load_req before is_loaded abandons the load; no pulse follows.
// RAM side: mem_rd_en is a one-cycle strobe with mem_addr; mem_rd_data is
// valid a fixed number of cycles later.
interface mem_load_responder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);

  logic              load_req;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_to_mdr;
  logic              is_loaded;
  logic              busy;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd_data;

  // Responder side.
  modport slave (
    input  load_req, load_addr, mem_rd_data,
    output load_to_mdr, is_loaded, busy, mem_rd_en, mem_addr
  );

  // Environment side (CPU hub plus RAM).
  modport master (
    output load_req, load_addr, mem_rd_data,
    input  load_to_mdr, is_loaded, busy, mem_rd_en, mem_addr
  );

endinterface

// File: rtl/mem_load_responder.sv
// Memory-side responder for the CPU LOAD handshake. Accepts one load at a
// time, strobes a read into a fixed-latency synchronous RAM, and returns the
// word with a one-cycle is_loaded pulse. All outputs are registered.
module mem_load_responder
  import mem_load_responder_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int MEM_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_load_responder_if.slave  bus,
  output load_state_t          dbg_state
);

  generate
    if (MEM_LATENCY < 1 || MEM_LATENCY > MAX_LATENCY) begin : g_bad_latency
      $error("mem_load_responder: MEM_LATENCY must be within 1..15");
    end
  endgenerate

  // Counter reload value: WAIT/DRAIN run until the counter reaches zero, which
  // is the cycle the RAM data is valid.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  load_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cnt_zero;

  logic              mem_rd_en_q, mem_rd_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] load_to_mdr_q, load_to_mdr_d;
  logic              is_loaded_q, is_loaded_d;
  logic              busy_q, busy_d;

  logic              accept;
  logic              capture;

  assign cnt_zero = (cnt_q == '0);
  assign accept   = (state_q == IDLE) && bus.load_req;
  assign capture  = (state_q == WAIT) && cnt_zero && bus.load_req;

  // State, latency counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      mem_rd_en_q   <= 1'b0;
      mem_addr_q    <= '0;
      load_to_mdr_q <= '0;
      is_loaded_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_addr_q    <= mem_addr_d;
      load_to_mdr_q <= load_to_mdr_d;
      is_loaded_q   <= is_loaded_d;
      busy_q        <= busy_d;
    end
  end

  // Next state and counter; an abort never cancels the read, it drains it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.load_req) state_d = ISSUE;
      end
      ISSUE: begin
        cnt_d   = CNT_LOAD;
        state_d = bus.load_req ? WAIT : DRAIN;
      end
      WAIT: begin
        if (cnt_zero) begin
          state_d = bus.load_req ? DONE : IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (!bus.load_req) state_d = DRAIN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      DRAIN: begin
        if (cnt_zero) state_d = IDLE;
        else          cnt_d   = cnt_q - CNT_W'(1);
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Next values of the registered outputs, derived from the transition taken.
  always_comb begin
    mem_rd_en_d   = accept;
    mem_addr_d    = accept ? bus.load_addr : mem_addr_q;
    load_to_mdr_d = capture ? bus.mem_rd_data : load_to_mdr_q;
    is_loaded_d   = capture;
    busy_d        = (state_d != IDLE);
  end

  assign bus.mem_rd_en   = mem_rd_en_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.load_to_mdr = load_to_mdr_q;
  assign bus.is_loaded   = is_loaded_q;
  assign bus.busy        = busy_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_mem_load_responder.sv
// Bench for mem_load_responder: three instances (latency 1, 3, 4) share the
// CPU-side stimulus, each with its own RAM model; one is observed per row.
module tb_mem_load_responder;
  import mem_load_responder_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        load_req = 1'b0;
  logic [15:0] load_addr = 16'h0000;
  int          sel = 1;

  mem_load_responder_if #(.DATA_W(16), .ADDR_W(16)) bus1 ();
  mem_load_responder_if #(.DATA_W(16), .ADDR_W(16)) bus3 ();
  mem_load_responder_if #(.DATA_W(16), .ADDR_W(16)) bus4 ();
  load_state_t dbg1, dbg3, dbg4;

  mem_load_responder #(.DATA_W(16), .ADDR_W(16), .MEM_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .dbg_state(dbg1));
  mem_load_responder #(.DATA_W(16), .ADDR_W(16), .MEM_LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3), .dbg_state(dbg3));
  mem_load_responder #(.DATA_W(16), .ADDR_W(16), .MEM_LATENCY(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4), .dbg_state(dbg4));

  assign bus1.load_req  = load_req;
  assign bus1.load_addr = load_addr;
  assign bus3.load_req  = load_req;
  assign bus3.load_addr = load_addr;
  assign bus4.load_req  = load_req;
  assign bus4.load_addr = load_addr;

  // ---------------- RAM models ----------------
  function automatic logic [15:0] ram_read(input logic [15:0] a);
    case (a)
      16'h0040: ram_read = 16'hBEEF;
      16'h1234: ram_read = 16'h5A5A;
      16'h0010: ram_read = 16'h1111;
      16'h0011: ram_read = 16'h2222;
      16'h0020: ram_read = 16'hC0DE;
      16'h0030: ram_read = 16'h3333;
      16'h0050: ram_read = 16'h5050;
      16'h0060: ram_read = 16'h6666;
      16'h0070: ram_read = 16'h7777;
      default:  ram_read = a ^ 16'hA5A5;
    endcase
  endfunction

  // Read data is only meaningful exactly LATENCY cycles after the strobe;
  // otherwise the pipe carries a poison word.
  logic [15:0] p1 [1];
  logic [15:0] p3 [3];
  logic [15:0] p4 [4];

  always @(posedge clk) begin
    p1[0] <= bus1.mem_rd_en ? ram_read(bus1.mem_addr) : 16'hDEAD;
    p3[0] <= bus3.mem_rd_en ? ram_read(bus3.mem_addr) : 16'hDEAD;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
    p4[0] <= bus4.mem_rd_en ? ram_read(bus4.mem_addr) : 16'hDEAD;
    p4[1] <= p4[0];
    p4[2] <= p4[1];
    p4[3] <= p4[2];
  end

  assign bus1.mem_rd_data = p1[0];
  assign bus3.mem_rd_data = p3[2];
  assign bus4.mem_rd_data = p4[3];

  // Observed instance.
  logic        o_rd, o_ld, o_busy;
  logic [15:0] o_addr, o_mdr;
  always_comb begin
    o_rd = bus4.mem_rd_en; o_addr = bus4.mem_addr; o_ld = bus4.is_loaded;
    o_mdr = bus4.load_to_mdr; o_busy = bus4.busy;
    if (sel == 1) begin
      o_rd = bus1.mem_rd_en; o_addr = bus1.mem_addr; o_ld = bus1.is_loaded;
      o_mdr = bus1.load_to_mdr; o_busy = bus1.busy;
    end else if (sel == 3) begin
      o_rd = bus3.mem_rd_en; o_addr = bus3.mem_addr; o_ld = bus3.is_loaded;
      o_mdr = bus3.load_to_mdr; o_busy = bus3.busy;
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int row, input logic [15:0] act,
                     input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    load_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          rst_before;
    int          sel;
    logic        req;
    logic [15:0] addr;
    logic        e_rd;
    logic [15:0] e_addr;
    logic        e_ld;
    logic [15:0] e_mdr;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(bit rb, int s, logic r, logic [15:0] a, logic erd,
                             logic [15:0] ea, logic eld, logic [15:0] em,
                             logic eb);
    vec_t t;
    t.rst_before = rb; t.sel = s; t.req = r; t.addr = a; t.e_rd = erd;
    t.e_addr = ea; t.e_ld = eld; t.e_mdr = em; t.e_busy = eb;
    return t;
  endfunction

  initial begin
    // Single load, latency 1: strobe in cycle 1, pulse in cycle 3.
    vecs.push_back(v(1, 1, 1, 16'h0040, 0, 16'h0000, 0, 16'h0000, 0));
    vecs.push_back(v(0, 1, 1, 16'h0040, 1, 16'h0040, 0, 16'h0000, 1));
    vecs.push_back(v(0, 1, 1, 16'h0040, 0, 16'h0040, 0, 16'h0000, 1));
    vecs.push_back(v(0, 1, 1, 16'h0040, 0, 16'h0040, 1, 16'hBEEF, 1));
    vecs.push_back(v(0, 1, 0, 16'h0040, 0, 16'h0040, 0, 16'hBEEF, 0));
    vecs.push_back(v(0, 1, 0, 16'h0040, 0, 16'h0040, 0, 16'hBEEF, 0));
    // Single load, latency 4: pulse in cycle 6, busy in cycles 1-6.
    vecs.push_back(v(1, 4, 1, 16'h1234, 0, 16'h0000, 0, 16'h0000, 0));
    vecs.push_back(v(0, 4, 1, 16'h1234, 1, 16'h1234, 0, 16'h0000, 1));
    for (int i = 0; i < 4; i++)
      vecs.push_back(v(0, 4, 1, 16'h1234, 0, 16'h1234, 0, 16'h0000, 1));
    vecs.push_back(v(0, 4, 1, 16'h1234, 0, 16'h1234, 1, 16'h5A5A, 1));
    vecs.push_back(v(0, 4, 0, 16'h1234, 0, 16'h1234, 0, 16'h5A5A, 0));
    // Back-to-back, latency 1: pulses in cycles 3 and 7.
    vecs.push_back(v(1, 1, 1, 16'h0010, 0, 16'h0000, 0, 16'h0000, 0));
    vecs.push_back(v(0, 1, 1, 16'h0010, 1, 16'h0010, 0, 16'h0000, 1));
    vecs.push_back(v(0, 1, 1, 16'h0010, 0, 16'h0010, 0, 16'h0000, 1));
    vecs.push_back(v(0, 1, 1, 16'h0010, 0, 16'h0010, 1, 16'h1111, 1));
    vecs.push_back(v(0, 1, 1, 16'h0011, 0, 16'h0010, 0, 16'h1111, 0));
    vecs.push_back(v(0, 1, 1, 16'h0011, 1, 16'h0011, 0, 16'h1111, 1));
    vecs.push_back(v(0, 1, 1, 16'h0011, 0, 16'h0011, 0, 16'h1111, 1));
    vecs.push_back(v(0, 1, 1, 16'h0011, 0, 16'h0011, 1, 16'h2222, 1));
    vecs.push_back(v(0, 1, 0, 16'h0011, 0, 16'h0011, 0, 16'h2222, 0));
    // Latency 3: a good load, then an abort in WAIT with a request during DRAIN.
    vecs.push_back(v(1, 3, 1, 16'h0030, 0, 16'h0000, 0, 16'h0000, 0));
    vecs.push_back(v(0, 3, 1, 16'h0030, 1, 16'h0030, 0, 16'h0000, 1));
    for (int i = 0; i < 3; i++)
      vecs.push_back(v(0, 3, 1, 16'h0030, 0, 16'h0030, 0, 16'h0000, 1));
    vecs.push_back(v(0, 3, 1, 16'h0030, 0, 16'h0030, 1, 16'h3333, 1));
    vecs.push_back(v(0, 3, 0, 16'h0030, 0, 16'h0030, 0, 16'h3333, 0));
    vecs.push_back(v(0, 3, 1, 16'h0060, 0, 16'h0030, 0, 16'h3333, 0));
    vecs.push_back(v(0, 3, 1, 16'h0060, 1, 16'h0060, 0, 16'h3333, 1));
    vecs.push_back(v(0, 3, 0, 16'h0060, 0, 16'h0060, 0, 16'h3333, 1));
    vecs.push_back(v(0, 3, 1, 16'h0070, 0, 16'h0060, 0, 16'h3333, 1));
    vecs.push_back(v(0, 3, 1, 16'h0070, 0, 16'h0060, 0, 16'h3333, 1));
    vecs.push_back(v(0, 3, 1, 16'h0070, 0, 16'h0060, 0, 16'h3333, 0));
    vecs.push_back(v(0, 3, 1, 16'h0070, 1, 16'h0070, 0, 16'h3333, 1));
    for (int i = 0; i < 3; i++)
      vecs.push_back(v(0, 3, 1, 16'h0070, 0, 16'h0070, 0, 16'h3333, 1));
    vecs.push_back(v(0, 3, 1, 16'h0070, 0, 16'h0070, 1, 16'h7777, 1));
    vecs.push_back(v(0, 3, 0, 16'h0070, 0, 16'h0070, 0, 16'h7777, 0));
    // load_addr moves to 0xFFFF right after acceptance of 0x0020.
    vecs.push_back(v(1, 1, 1, 16'h0020, 0, 16'h0000, 0, 16'h0000, 0));
    vecs.push_back(v(0, 1, 1, 16'hFFFF, 1, 16'h0020, 0, 16'h0000, 1));
    vecs.push_back(v(0, 1, 1, 16'hFFFF, 0, 16'h0020, 0, 16'h0000, 1));
    vecs.push_back(v(0, 1, 1, 16'hFFFF, 0, 16'h0020, 1, 16'hC0DE, 1));
    vecs.push_back(v(0, 1, 0, 16'hFFFF, 0, 16'h0020, 0, 16'hC0DE, 0));

    // ---------------- apply table ----------------
    for (int r = 0; r < vecs.size(); r++) begin
      if (vecs[r].rst_before) do_reset();
      else @(negedge clk);
      sel       = vecs[r].sel;
      load_req  = vecs[r].req;
      load_addr = vecs[r].addr;
      #1;
      chk("mem_rd_en",   r, 16'(o_rd),   16'(vecs[r].e_rd));
      chk("mem_addr",    r, o_addr,      vecs[r].e_addr);
      chk("is_loaded",   r, 16'(o_ld),   16'(vecs[r].e_ld));
      chk("load_to_mdr", r, o_mdr,       vecs[r].e_mdr);
      chk("busy",        r, 16'(o_busy), 16'(vecs[r].e_busy));
    end

    // ---------------- async reset in WAIT (latency 4) ----------------
    sel = 4;
    do_reset();
    load_req  = 1'b1;
    load_addr = 16'h0050;
    @(negedge clk);
    #1;
    chk("arst_issue_rd_en", 100, 16'(bus4.mem_rd_en), 16'h0001);
    chk("arst_issue_addr",  100, bus4.mem_addr, 16'h0050);
    @(negedge clk);
    @(posedge clk);
    #2;
    chk("arst_pre_state", 101, 16'(dbg4), 16'(WAIT));
    rst_n = 1'b0;
    #1;
    chk("arst_addr",  102, bus4.mem_addr, 16'h0000);
    chk("arst_rd_en", 102, 16'(bus4.mem_rd_en), 16'h0000);
    chk("arst_ld",    102, 16'(bus4.is_loaded), 16'h0000);
    chk("arst_mdr",   102, bus4.load_to_mdr, 16'h0000);
    chk("arst_busy",  102, 16'(bus4.busy), 16'h0000);
    chk("arst_state", 102, 16'(dbg4), 16'(IDLE));
    load_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    // The RAM response for 0x0050 lands in this window and must be ignored.
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      chk("stale_ld",   110 + c, 16'(bus4.is_loaded), 16'h0000);
      chk("stale_busy", 110 + c, 16'(bus4.busy), 16'h0000);
      chk("stale_mdr",  110 + c, bus4.load_to_mdr, 16'h0000);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
